// File: rtl/cipher_cfg_regbank_if.sv
// Host register-access bus for cipher_cfg_regbank: a single-cycle strobe
// request followed by a registered done/error/rdata response.
interface cipher_cfg_regbank_if #(
  parameter int unsigned addr_width = 8,
  parameter int unsigned reg_width  = 16
);
  logic [addr_width-1:0] addr;
  logic                  read;
  logic                  write;
  logic [reg_width-1:0]  wdata;
  logic [reg_width-1:0]  rdata;
  logic                  done;
  logic                  error;

  modport master (output addr, read, write, wdata, input  rdata, done, error);
  modport slave  (input  addr, read, write, wdata, output rdata, done, error);
endinterface

// File: rtl/cipher_cfg_regbank.sv
// Cipher configuration register bank: shadow select/keys are committed
// atomically to the active outputs once the cipher datapath is idle.
module cipher_cfg_regbank #(
  parameter int unsigned addr_width = 8,
  parameter int unsigned reg_width  = 16,
  parameter int unsigned NUM_KEYS   = 3,
  parameter int unsigned KEY_BASE   = 8'h10,
  parameter int unsigned KEY_STRIDE = 2,
  parameter logic [NUM_KEYS*reg_width-1:0] KEY_RST = {16'h0002, 16'hFFFF, 16'h0000}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cipher_cfg_regbank_if.slave           bus,
  input  logic                          busy,
  output logic [reg_width-1:0]          select,
  output logic [NUM_KEYS*reg_width-1:0] keys,
  output logic                          cfg_update
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                        state, state_next;
  logic [1:0]                    shadow_sel, active_sel;
  logic [NUM_KEYS*reg_width-1:0] shadow_keys, active_keys;
  logic                          locked;
  logic                          pending;
  logic                          commit_now;

  logic                 sel_hit, ctrl_hit, stat_hit, key_hit;
  logic [2:0]           key_idx;
  logic                 any_req, acc_err, wr_ok, rd_ok;
  logic [reg_width-1:0] rd_val;

  assign pending    = (state == PENDING);
  assign commit_now = pending && !busy;
  assign select     = {{(reg_width-2){1'b0}}, active_sel};
  assign keys       = active_keys;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_hit  = (bus.addr == '0);
    ctrl_hit = (bus.addr == addr_width'(2));
    stat_hit = (bus.addr == addr_width'(4));
    key_hit  = 1'b0;
    key_idx  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (bus.addr == addr_width'(KEY_BASE + KEY_STRIDE * i)) begin
        key_hit = 1'b1;
        key_idx = 3'(i);
      end
    end

    any_req = bus.read | bus.write;
    acc_err = (bus.read & bus.write)
            | ~(sel_hit | ctrl_hit | stat_hit | key_hit)
            | (bus.write & stat_hit)
            | (bus.read & ctrl_hit)
            | (bus.write & locked)
            | (bus.write & (sel_hit | key_hit) & pending);
    wr_ok = bus.write & ~acc_err;
    rd_ok = bus.read & ~acc_err;

    // Reads return the shadow copy so software sees what it last wrote.
    rd_val = '0;
    if (sel_hit)       rd_val = {{(reg_width-2){1'b0}}, shadow_sel};
    else if (stat_hit) rd_val = {{(reg_width-2){1'b0}}, locked, pending};
    else if (key_hit)  rd_val = shadow_keys[int'(key_idx)*reg_width +: reg_width];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (wr_ok && ctrl_hit && bus.wdata[0]) state_next = PENDING;
      PENDING: if (!busy)                             state_next = IDLE;
      default:                                        state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.done  <= any_req;
      bus.error <= any_req & acc_err;
      bus.rdata <= rd_ok ? rd_val : '0;
    end
  end

  // NOTE: the key storage is reset because software relies on KEY_RST being readable before any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_sel  <= '0;
      shadow_keys <= KEY_RST;
      locked      <= 1'b0;
    end else if (wr_ok) begin
      if (sel_hit) shadow_sel <= bus.wdata[1:0];
      if (key_hit) shadow_keys[int'(key_idx)*reg_width +: reg_width] <= bus.wdata;
      if (ctrl_hit && bus.wdata[1]) locked <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_sel  <= '0;
      active_keys <= KEY_RST;
      cfg_update  <= 1'b0;
    end else begin
      cfg_update <= commit_now;
      if (commit_now) begin
        active_sel  <= shadow_sel;
        active_keys <= shadow_keys;
      end
    end
  end

endmodule

// File: doc/cipher_cfg_regbank.md
Name: cipher_cfg_regbank

Overview:
- Parametrised successor to the decryption register bank.
- Holds the cipher select value and NUM_KEYS cipher keys.
- Host writes land in shadow registers; an explicit commit copies them atomically to the active outputs, and only while the cipher datapath reports idle. This prevents mid-message key changes.
- Adds a sticky lock bit and a read-only status register.
- Sits between the host register interface and the MUX/DEMUX and cipher blocks.

Parameters:
- addr_width, 8, address bus width.
- reg_width, 16, data and key register width.
- NUM_KEYS, 3, number of key registers; minimum 1, maximum 8.
- KEY_BASE, 8'h10, address of key 0.
- KEY_STRIDE, 2, address step between consecutive keys.
- KEY_RST, {16'h0002,16'hFFFF,16'h0000}, flattened per-key reset values; key i occupies slice [i*reg_width +: reg_width].

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- addr  in  addr_width  register address.
- read  in  1  read strobe, sampled on the rising edge.
- write  in  1  write strobe, sampled on the rising edge.
- wdata  in  reg_width  write data.
- rdata  out  reg_width  registered read data.
- done  out  1  access-complete pulse.
- error  out  1  access-error flag, valid while done=1.
- busy  in  1  cipher datapath busy; a commit is deferred while this is 1.
- select  out  reg_width  active select; only bits [1:0] can be nonzero.
- keys  out  NUM_KEYS*reg_width  active keys, flattened.
- cfg_update  out  1  one-cycle pulse in the cycle after the active values change.

Behaviour:
Address map:
- 0x00 SELECT, RW; only wdata[1:0] is stored, upper bits store as 0.
- 0x02 CTRL, W.
  - bit0 COMMIT: self-clearing, reads as 0.
  - bit1 LOCK: sticky until reset.
- 0x04 STATUS, RO: {zeros, locked, pending}.
- KEY_BASE + KEY_STRIDE*i for i < NUM_KEYS: KEY_i, RW.
- Any other address is invalid.

Reset (asynchronous, rst_n=0):
- rdata=0, done=0, error=0, cfg_update=0, pending=0, locked=0.
- Shadow select and active select = 0.
- Shadow keys and active keys = KEY_RST.

Access handshake:
- A request is read or write high at a rising edge N.
- done=1 during cycle N+1 and is 0 otherwise; there are no wait states.
- Back-to-back accesses on consecutive edges are each acknowledged.
- rdata is valid during cycle N+1 for a successful read. It is 0 for writes, for errors and when idle.
- Reads of SELECT or KEY_i return the SHADOW value, not the active value.

Error cases (done=1, error=1, rdata=0, no state change):
- invalid address;
- read and write asserted together;
- write to STATUS;
- read of CTRL;
- any write while locked=1;
- write to SELECT or KEY_i while pending=1.

Commit state machine, states IDLE and PENDING:
- IDLE → PENDING: a successful CTRL write with wdata[0]=1 sets pending at edge N.
- While PENDING, at each edge where busy=0: copy shadow values to active, clear pending, and drive cfg_update=1 for the following cycle.
- Earliest update timing: commit sampled at edge N, busy=0 at edge N+1 → active values change after N+1, and cfg_update is high during cycle N+2.
- While PENDING with busy=1: wait indefinitely; active outputs hold.
- A COMMIT write while already PENDING succeeds (error=0) but has no additional effect. There is no queueing and no second cfg_update.
- A CTRL write with bit1=1 sets locked. It may combine with bit0 in the same write; the commit proceeds normally and writes are blocked afterwards.
- A CTRL write with both bits 0 succeeds and does nothing.

Reset mid-operation:
- Reset during PENDING drops the commit.
- Active values return to their reset values immediately, without waiting for the clock.
- No cfg_update is generated.

Test Plan:
1. Reset, then read 0x00, 0x10, 0x12, 0x14 → rdata 0x0000, 0x0000, 0xFFFF, 0x0002, each with done=1 and error=0; keys output = {0002,FFFF,0000}.
2. Write 0x12=0x0005, write 0x00=0x00FE, commit with busy=0 → shadow select reads 0x0002; active values unchanged until the commit; then scytale key=0x0005 and select=0x0002; one cfg_update pulse exactly 2 cycles after the commit edge.
3. Hold busy=1, commit, wait 10 cycles → STATUS=0x0001 and active values held. A write to 0x10 gives error=1. Release busy → update completes, cfg_update pulses once, STATUS=0x0000.
4. Invalid accesses, each → error=1, rdata=0, no state change:
   - read 0x01;
   - write 0x16 with NUM_KEYS=3;
   - read and write together at 0x10;
   - write to 0x04.
5. Write CTRL=0x0003 → commit completes; STATUS=0x0002; write 0x14=0x0009 gives error=1; keys unchanged.
6. Commit with busy=1, then pulse rst_n low mid-wait → all outputs return to reset values asynchronously; pending=0; no cfg_update after reset is released.
